param_traffic_light_controller: RTL and testbench
=================================================

# param_traffic_light_controller

Parametrised two-direction intersection controller for the FSM block family. Phase durations are set by parameters. It adds an optional all-red clearance interval, a latched pedestrian walk phase and a flashing night mode. The block is a standalone Moore FSM driving one-hot lamp outputs, with a free-running phase timer.

## Interface
- GREEN_CYCLES, 3, green duration per direction; must be ≥1
- YELLOW_CYCLES, 2, yellow duration; must be ≥1
- ALL_RED_CYCLES, 1, clearance after each yellow; 0 removes the clearance state
- WALK_CYCLES, 4, pedestrian walk duration; must be ≥1
- FLASH_HALF_CYCLES, 2, lamp on-time and off-time in flash mode; must be ≥1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  when 0, state, timer and blink are frozen; ped_req is still latched
- ped_req  in  1  pedestrian request, level or pulse, sampled each edge
- flash_mode  in  1  night mode request
- ns_light  out  3  {red,yellow,green} one-hot; 3'b000 means dark
- ew_light  out  3  same encoding as ns_light
- ped_walk  out  1  walk lamp
- ped_pending  out  1  latched request not yet served

## Operation
- Encodings: RED=100, YELLOW=010, GREEN=001, OFF=000. Outputs are a pure decode of the state register, with no input-to-output combinational path.
- States: NS_GREEN, NS_YELLOW, CLR_A, EW_GREEN, EW_YELLOW, CLR_B, WALK, FLASH.
- Normal cycle: NS_GREEN→NS_YELLOW→CLR_A→EW_GREEN→EW_YELLOW→CLR_B→NS_GREEN.
- Bypass: if ALL_RED_CYCLES=0, CLR_A and CLR_B are skipped.
- Lamps: in CLR_x and WALK both directions show RED. ped_walk=1 only in WALK.
- Pedestrian service: ped_pending is set by ped_req=1 on any edge. At the exit of a clearance point (CLR_x end, or YELLOW end when ALL_RED_CYCLES=0), a set ped_pending routes to WALK instead of the next green. WALK then exits to the green that would have followed.
- ped_pending clears on the edge entering WALK. A ped_req arriving during WALK, including on the entry edge, re-sets it for the next clearance point.
- Flash mode: flash_mode=1 sampled on any edge with en=1 enters FLASH on that edge, from any state. It aborts the current phase. It has priority over the pedestrian routing.
- In FLASH, blink starts at 1 and toggles every FLASH_HALF_CYCLES edges. Lamps: ns=YELLOW, ew=RED while blink=1; both OFF while blink=0.
- Leaving FLASH: flash_mode=0 exits to CLR_B, or to NS_GREEN if ALL_RED_CYCLES=0. ped_pending is preserved across FLASH.
- Timer width is $clog2(max parameter + 1). The timer reloads on every state change.

## Timing
- Reset (rst_n=0, asynchronous): state NS_GREEN, timer cleared, blink=1, ped_pending=0. Outputs: ns=GREEN, ew=RED, ped_walk=0.
- Reset time does not count toward any phase.
- Phase length: each phase of length N is visible in exactly N consecutive samples taken after rising edges. It is left on the (N+1)-th edge.
- This rule applies to the first NS_GREEN after rst_n rises: samples after post-reset edges 1..GREEN_CYCLES show green.
- Latency: ped_req to ped_pending is 1 edge. flash_mode to FLASH lamps is 1 edge.
- en=0 stretches the current phase by one cycle per low cycle. No outputs change while en=0.
- Reset mid-phase returns to the reset state immediately, without waiting for a clock edge.

## Structure
- Shared package traffic_pkg holds:
  - the lamp encodings RED/YELLOW/GREEN/OFF
  - the state enum
  - a function mapping state+blink to {ns,ew,walk}
- One sub-module, tl_phase_timer:
  - loadable down-counter, parameterised width
  - load value and done flag
  - en gating

## Test plan
- Defaults, no requests. Samples after edges 1-3: NS G/EW R; 4-5: NS Y; 6: all red; 7-9: EW G; 10-11: EW Y; 12: all red; 13: NS G.
- ped_req pulse on edge 2. ped_pending=1 after edge 2; edge 6: all red; edges 7-10: ped_walk=1, both RED, ped_pending=0; edges 11-13: EW G.
- ALL_RED_CYCLES=0, GREEN=2, YELLOW=1. Sequence per sample: NS G,G,Y; EW G,G,Y; NS G. No all-red sample appears.
- flash_mode=1 on edge 2, held for 8 edges. Edges 2-3: ns=Y, ew=R; 4-5: both OFF; 6-7: Y/R; 8-9: OFF. After flash_mode falls: one all-red sample, then NS G for 3 samples.
- en=0 for 5 cycles during EW_GREEN. Lamps are frozen and EW green lasts 8 samples total. A ped_req issued while en=0 still sets ped_pending.
- rst_n pulsed low mid-EW_YELLOW, between edges. Outputs go to NS G/EW R immediately, ped_pending=0, and the default sequence restarts from edge 1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, controller state set and the state-to-lamp decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        CLR_A,
        EW_GREEN,
        EW_YELLOW,
        CLR_B,
        WALK,
        FLASH
    } state_t;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    // Moore decode: lamps depend only on the state register and the blink phase.
    function automatic lamps_t decode_lamps(input state_t s, input logic blink);
        lamps_t l;
        l.ns   = RED;
        l.ew   = RED;
        l.walk = 1'b0;
        case (s)
            NS_GREEN:  l.ns = GREEN;
            NS_YELLOW: l.ns = YELLOW;
            EW_GREEN:  l.ew = GREEN;
            EW_YELLOW: l.ew = YELLOW;
            WALK:      l.walk = 1'b1;
            FLASH: begin
                l.ns = blink ? YELLOW : OFF;
                l.ew = blink ? RED    : OFF;
            end
            default: ;
        endcase
        return l;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter timing the current phase; done while the count is zero.
// Latency: load takes effect on the edge it is sampled; done is a decode of the count.
// Backpressure: en=0 freezes the count, including pending loads.
module tl_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/param_traffic_light_controller.sv
// Two-direction intersection controller with all-red clearance, latched walk and night flash.
// Latency: ped_req -> ped_pending 1 edge; flash_mode -> flash lamps 1 edge; lamps decode state only.
// Backpressure: en=0 stalls state, timer and blink; ped_req is still latched.
module param_traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES      = 3,
    parameter int YELLOW_CYCLES     = 2,
    parameter int ALL_RED_CYCLES    = 1,
    parameter int WALK_CYCLES       = 4,
    parameter int FLASH_HALF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic       ped_pending
);

    localparam int MAX_P = max_of(max_of(GREEN_CYCLES, YELLOW_CYCLES),
                                  max_of(max_of(ALL_RED_CYCLES, WALK_CYCLES), FLASH_HALF_CYCLES));
    localparam int TW    = $clog2(MAX_P + 1);
    localparam bit HAS_CLR = (ALL_RED_CYCLES > 0);

    // Timer holds "edges remaining after this one", so each phase loads length-1.
    localparam logic [TW-1:0] LD_GREEN  = TW'(GREEN_CYCLES - 1);
    localparam logic [TW-1:0] LD_YELLOW = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] LD_CLR    = TW'(HAS_CLR ? ALL_RED_CYCLES - 1 : 0);
    localparam logic [TW-1:0] LD_WALK   = TW'(WALK_CYCLES - 1);
    localparam logic [TW-1:0] LD_FLASH  = TW'(FLASH_HALF_CYCLES - 1);

    state_t        state, next_state;
    logic          blink, blink_nxt;
    logic          ret_ew, ret_ew_nxt;
    logic          armed;
    logic          timer_done, phase_done;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          entering_walk;
    lamps_t        lamps;

    // The reset state is already on display before edge 1, so the timer only
    // becomes meaningful once the first enabled edge has loaded it.
    assign phase_done    = timer_done & armed;
    assign entering_walk = (next_state == WALK) && (state != WALK);

    // Next-state, walk return direction, blink and timer reload.
    always_comb begin
        next_state = state;
        ret_ew_nxt = ret_ew;
        blink_nxt  = 1'b1;
        timer_val  = LD_GREEN;

        if (flash_mode) begin
            next_state = FLASH;
        end else begin
            case (state)
                NS_GREEN:  if (phase_done) next_state = NS_YELLOW;
                NS_YELLOW: if (phase_done) next_state = HAS_CLR ? CLR_A : (ped_pending ? WALK : EW_GREEN);
                CLR_A:     if (phase_done) next_state = ped_pending ? WALK : EW_GREEN;
                EW_GREEN:  if (phase_done) next_state = EW_YELLOW;
                EW_YELLOW: if (phase_done) next_state = HAS_CLR ? CLR_B : (ped_pending ? WALK : NS_GREEN);
                CLR_B:     if (phase_done) next_state = ped_pending ? WALK : NS_GREEN;
                WALK:      if (phase_done) next_state = ret_ew ? EW_GREEN : NS_GREEN;
                FLASH:     next_state = HAS_CLR ? CLR_B : NS_GREEN;
                default:   next_state = NS_GREEN;
            endcase
        end

        // A walk inserted after the NS half of the cycle must hand over to EW.
        if (entering_walk) begin
            ret_ew_nxt = (state == NS_YELLOW) || (state == CLR_A);
        end

        if (next_state == FLASH) begin
            if (state != FLASH) begin
                blink_nxt = 1'b1;
            end else begin
                blink_nxt = phase_done ? ~blink : blink;
            end
        end

        case (next_state)
            NS_GREEN, EW_GREEN:   timer_val = LD_GREEN;
            NS_YELLOW, EW_YELLOW: timer_val = LD_YELLOW;
            CLR_A, CLR_B:         timer_val = LD_CLR;
            WALK:                 timer_val = LD_WALK;
            FLASH:                timer_val = LD_FLASH;
            default:              timer_val = LD_GREEN;
        endcase

        timer_load = (next_state != state) || !armed || ((state == FLASH) && phase_done);
    end

    // State, blink phase and walk return direction advance only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= NS_GREEN;
            blink  <= 1'b1;
            ret_ew <= 1'b0;
            armed  <= 1'b0;
        end else if (en) begin
            state  <= next_state;
            blink  <= blink_nxt;
            ret_ew <= ret_ew_nxt;
            armed  <= 1'b1;
        end
    end

    // Pedestrian latch runs regardless of en; a request on the walk entry edge re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (en && entering_walk) begin
            ped_pending <= ped_req;
        end else begin
            ped_pending <= ped_pending | ped_req;
        end
    end

    tl_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    assign lamps    = decode_lamps(state, blink);
    assign ns_light = lamps.ns;
    assign ew_light = lamps.ew;
    assign ped_walk = lamps.walk;

endmodule

// File: tb/tb_param_traffic_light_controller.sv
// Table-driven bench with an expected-value queue for the traffic light controller.
// Latency: each vector's expectation is checked 1 ns after the edge it drives.
// Backpressure: n/a.
module tb_param_traffic_light_controller;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] L_O = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en, ped_req, flash_mode;
    logic [2:0] ns_light, ew_light;
    logic       ped_walk, ped_pending;

    logic       en2, ped_req2, flash_mode2;
    logic [2:0] ns_light2, ew_light2;
    logic       ped_walk2, ped_pending2;

    always #5 clk = ~clk;

    param_traffic_light_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ped_req     (ped_req),
        .flash_mode  (flash_mode),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending)
    );

    param_traffic_light_controller #(
        .GREEN_CYCLES      (2),
        .YELLOW_CYCLES     (1),
        .ALL_RED_CYCLES    (0),
        .WALK_CYCLES       (4),
        .FLASH_HALF_CYCLES (2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en2),
        .ped_req     (ped_req2),
        .flash_mode  (flash_mode2),
        .ns_light    (ns_light2),
        .ew_light    (ew_light2),
        .ped_walk    (ped_walk2),
        .ped_pending (ped_pending2)
    );

    typedef struct {
        logic       en;
        logic       ped;
        logic       fl;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       pend;
        logic       c2;
        logic [2:0] ns2;
        logic [2:0] ew2;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;
    vec_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input int rep, input logic e, input logic p, input logic f,
                       input logic [2:0] ns, input logic [2:0] ew, input logic w, input logic pd);
        for (int k = 0; k < rep; k++) begin
            vecs[nv].en   = e;
            vecs[nv].ped  = p;
            vecs[nv].fl   = f;
            vecs[nv].ns   = ns;
            vecs[nv].ew   = ew;
            vecs[nv].walk = w;
            vecs[nv].pend = pd;
            vecs[nv].c2   = 1'b0;
            vecs[nv].ns2  = L_O;
            vecs[nv].ew2  = L_O;
            nv++;
        end
    endtask

    task automatic set2(input int idx, input logic [2:0] ns, input logic [2:0] ew);
        vecs[idx].c2  = 1'b1;
        vecs[idx].ns2 = ns;
        vecs[idx].ew2 = ew;
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s[%0d]: got {ns,ew,walk,pend}=%b required %b", name, idx, act, expv);
        end
    endtask

    // Drive one vector per edge at the falling edge; compare 1 ns after the rising edge.
    task automatic run(input string name);
        vec_t x;
        for (int i = 0; i < nv; i++) begin
            en         = vecs[i].en;
            ped_req    = vecs[i].ped;
            flash_mode = vecs[i].fl;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            chk(name, i + 1, {ns_light, ew_light, ped_walk, ped_pending}, {x.ns, x.ew, x.walk, x.pend});
            if (x.c2) begin
                chk({name, "_dut2"}, i + 1, {ns_light2, ew_light2, ped_walk2, ped_pending2},
                    {x.ns2, x.ew2, 2'b00});
            end
            @(negedge clk);
        end
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        nv = 0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n      = 1'b0;
        en         = 1'b1;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk({name, "_rst"}, 0, {ns_light, ew_light, ped_walk, ped_pending}, {L_G, L_R, 2'b00});
        chk({name, "_rst_dut2"}, 0, {ns_light2, ew_light2, ped_walk2, ped_pending2}, {L_G, L_R, 2'b00});
        rst_n = 1'b1;
    endtask

    task automatic load_default();
        add(3, 1, 0, 0, L_G, L_R, 0, 0);
        add(2, 1, 0, 0, L_Y, L_R, 0, 0);
        add(1, 1, 0, 0, L_R, L_R, 0, 0);
        add(3, 1, 0, 0, L_R, L_G, 0, 0);
        add(2, 1, 0, 0, L_R, L_Y, 0, 0);
        add(1, 1, 0, 0, L_R, L_R, 0, 0);
        add(1, 1, 0, 0, L_G, L_R, 0, 0);
    endtask

    initial begin
        en = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
        en2 = 1'b1; ped_req2 = 1'b0; flash_mode2 = 1'b0;

        // Default cycle, with the no-clearance instance running alongside.
        do_reset("default");
        load_default();
        set2(0, L_G, L_R); set2(1, L_G, L_R); set2(2, L_Y, L_R);
        set2(3, L_R, L_G); set2(4, L_R, L_G); set2(5, L_R, L_Y);
        set2(6, L_G, L_R);
        run("default");

        // Pedestrian pulse on edge 2 is served after the first clearance.
        do_reset("ped");
        add(1, 1, 0, 0, L_G, L_R, 0, 0);
        add(1, 1, 1, 0, L_G, L_R, 0, 1);
        add(1, 1, 0, 0, L_G, L_R, 0, 1);
        add(2, 1, 0, 0, L_Y, L_R, 0, 1);
        add(1, 1, 0, 0, L_R, L_R, 0, 1);
        add(4, 1, 0, 0, L_R, L_R, 1, 0);
        add(3, 1, 0, 0, L_R, L_G, 0, 0);
        run("ped");

        // Flash mode held for edges 2..9, then clearance and NS green.
        do_reset("flash");
        add(1, 1, 0, 0, L_G, L_R, 0, 0);
        add(2, 1, 0, 1, L_Y, L_R, 0, 0);
        add(2, 1, 0, 1, L_O, L_O, 0, 0);
        add(2, 1, 0, 1, L_Y, L_R, 0, 0);
        add(2, 1, 0, 1, L_O, L_O, 0, 0);
        add(1, 1, 0, 0, L_R, L_R, 0, 0);
        add(3, 1, 0, 0, L_G, L_R, 0, 0);
        add(1, 1, 0, 0, L_Y, L_R, 0, 0);
        run("flash");

        // Request survives flash; request on the walk entry edge re-arms for the next clearance.
        do_reset("flash_ped");
        add(1, 1, 1, 0, L_G, L_R, 0, 1);
        add(2, 1, 0, 1, L_Y, L_R, 0, 1);
        add(1, 1, 0, 0, L_R, L_R, 0, 1);
        add(1, 1, 1, 0, L_R, L_R, 1, 1);
        add(3, 1, 0, 0, L_R, L_R, 1, 1);
        add(3, 1, 0, 0, L_G, L_R, 0, 1);
        add(2, 1, 0, 0, L_Y, L_R, 0, 1);
        add(1, 1, 0, 0, L_R, L_R, 0, 1);
        add(4, 1, 0, 0, L_R, L_R, 1, 0);
        add(1, 1, 0, 0, L_R, L_G, 0, 0);
        run("flash_ped");

        // en low for 5 edges in EW green stretches it to 8 samples; ped_req still latches.
        do_reset("stall");
        add(3, 1, 0, 0, L_G, L_R, 0, 0);
        add(2, 1, 0, 0, L_Y, L_R, 0, 0);
        add(1, 1, 0, 0, L_R, L_R, 0, 0);
        add(1, 1, 0, 0, L_R, L_G, 0, 0);
        add(2, 0, 0, 0, L_R, L_G, 0, 0);
        add(1, 0, 1, 0, L_R, L_G, 0, 1);
        add(2, 0, 0, 0, L_R, L_G, 0, 1);
        add(2, 1, 0, 0, L_R, L_G, 0, 1);
        add(2, 1, 0, 0, L_R, L_Y, 0, 1);
        add(1, 1, 0, 0, L_R, L_R, 0, 1);
        add(4, 1, 0, 0, L_R, L_R, 1, 0);
        add(1, 1, 0, 0, L_G, L_R, 0, 0);
        run("stall");

        // Asynchronous reset between edges in EW yellow, then the default cycle restarts.
        do_reset("midrst");
        add(3, 1, 0, 0, L_G, L_R, 0, 0);
        add(2, 1, 0, 0, L_Y, L_R, 0, 0);
        add(1, 1, 0, 0, L_R, L_R, 0, 0);
        add(1, 1, 0, 0, L_R, L_G, 0, 0);
        add(1, 1, 1, 0, L_R, L_G, 0, 1);
        add(1, 1, 0, 0, L_R, L_G, 0, 1);
        add(1, 1, 0, 0, L_R, L_Y, 0, 1);
        run("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 0, {ns_light, ew_light, ped_walk, ped_pending}, {L_G, L_R, 2'b00});
        @(negedge clk);
        rst_n = 1'b1;
        load_default();
        run("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
        $fatal(1);
    end

endmodule
